clock_step_controller: RTL and testbench

Run-control sequencer for the processor clock domain. Derives a one-cycle CPU clock-enable pulse (cpu_ce) from the free-running CLK using a programmable divider, and supports four modes: halted, free run, N-step, and breakpoint stop. It sits between the clock generator and the processor core, and is driven by the debug/testbench host through simple request pulses.

---
 rtl/clock_step_controller_if.sv | 28 ++
 rtl/clock_step_controller.sv | 112 +++++++++++
 tb/tb_clock_step_controller.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_step_controller_if.sv
// Host-side run-control bundle for clock_step_controller: request pulses in,
// clock-enable, run state, step-done pulse and cycle counter out.
interface clock_step_controller_if #(
  parameter int DIV_WIDTH  = 8,
  parameter int STEP_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
);
  logic                  run_req;
  logic                  halt_req;
  logic                  step_req;
  logic [STEP_WIDTH-1:0] step_count;
  logic [DIV_WIDTH-1:0]  div_ratio;
  logic                  bp_hit;
  logic                  cpu_ce;
  logic [1:0]            state;
  logic                  done;
  logic [CNT_WIDTH-1:0]  cycle_count;

  modport master (
    output run_req, halt_req, step_req, step_count, div_ratio, bp_hit,
    input  cpu_ce, state, done, cycle_count
  );

  modport slave (
    input  run_req, halt_req, step_req, step_count, div_ratio, bp_hit,
    output cpu_ce, state, done, cycle_count
  );
endinterface

// File: rtl/clock_step_controller.sv
// Run-control sequencer: divides CLK into a one-cycle cpu_ce pulse and sequences
// halted / free-run / N-step / breakpoint-stop modes from host request pulses.
module clock_step_controller #(
  parameter int DIV_WIDTH  = 8,
  parameter int STEP_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  clock_step_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_HALTED = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_BREAK  = 2'b11
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0]  div_lat_q, div_lat_d;
  logic [STEP_WIDTH-1:0] remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0]  cycle_count_q, cycle_count_d;
  logic                  done_q, done_d;
  logic                  cpu_ce;

  // Decoded purely from registers so the core never sees a combinational input path.
  assign cpu_ce = ((state_q == ST_RUN) || (state_q == ST_STEP)) && (div_cnt_q == div_lat_q);

  always_comb begin
    state_d       = state_q;
    div_lat_d     = div_lat_q;
    remaining_d   = remaining_q;
    done_d        = 1'b0;
    cycle_count_d = cycle_count_q + CNT_WIDTH'(cpu_ce);
    div_cnt_d     = cpu_ce ? '0 : div_cnt_q + DIV_WIDTH'(1);

    case (state_q)
      ST_HALTED, ST_BREAK: begin
        div_cnt_d = '0;
        if (bus.halt_req) begin
          state_d = ST_HALTED;
        end else if (bus.step_req) begin
          state_d     = ST_STEP;
          div_lat_d   = bus.div_ratio;
          remaining_d = (bus.step_count == '0) ? STEP_WIDTH'(1) : bus.step_count;
        end else if (bus.run_req) begin
          state_d   = ST_RUN;
          div_lat_d = bus.div_ratio;
        end
      end

      ST_RUN: begin
        if (bus.halt_req) begin
          state_d   = ST_HALTED;
          div_cnt_d = '0;
        end else if (bus.bp_hit && cpu_ce) begin
          state_d   = ST_BREAK;
          div_cnt_d = '0;
        end
      end

      ST_STEP: begin
        if (cpu_ce) begin
          remaining_d = remaining_q - STEP_WIDTH'(1);
        end
        // Halt and breakpoint both pre-empt a normal completion, so no done for them.
        if (bus.halt_req) begin
          state_d   = ST_HALTED;
          div_cnt_d = '0;
        end else if (bus.bp_hit && cpu_ce) begin
          state_d   = ST_BREAK;
          div_cnt_d = '0;
        end else if (cpu_ce && (remaining_q == STEP_WIDTH'(1))) begin
          state_d   = ST_HALTED;
          div_cnt_d = '0;
          done_d    = 1'b1;
        end
      end

      default: begin
        state_d   = ST_HALTED;
        div_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_HALTED;
      div_cnt_q     <= '0;
      div_lat_q     <= '0;
      remaining_q   <= '0;
      cycle_count_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      div_lat_q     <= div_lat_d;
      remaining_q   <= remaining_d;
      cycle_count_q <= cycle_count_d;
      done_q        <= done_d;
    end
  end

  assign bus.cpu_ce      = cpu_ce;
  assign bus.state       = state_q;
  assign bus.done        = done_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_clock_step_controller.sv
// Directed self-checking bench for clock_step_controller; a second instance with
// a 4-bit cycle counter exercises counter wrap-around cheaply.
module tb_clock_step_controller;

  localparam int DW  = 8;
  localparam int SW  = 16;
  localparam int CW  = 32;
  localparam int CW2 = 4;

  logic CLK = 1'b0;
  logic RST;
  int   testsRun    = 0;
  int   testsFailed = 0;

  always #5 CLK = ~CLK;

  clock_step_controller_if #(.DIV_WIDTH(DW), .STEP_WIDTH(SW), .CNT_WIDTH(CW))  bus ();
  clock_step_controller_if #(.DIV_WIDTH(DW), .STEP_WIDTH(SW), .CNT_WIDTH(CW2)) bus2 ();

  clock_step_controller #(.DIV_WIDTH(DW), .STEP_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  clock_step_controller #(.DIV_WIDTH(DW), .STEP_WIDTH(SW), .CNT_WIDTH(CW2)) dut2 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; the DUT samples them on the next rising edge
  // and results are observed on the falling edge after that.
  task automatic applyStimulus(input logic run, input logic halt, input logic stp, input logic bp);
    bus.run_req  = run;
    bus.halt_req = halt;
    bus.step_req = stp;
    bus.bp_hit   = bp;
    @(negedge CLK);
    bus.run_req  = 1'b0;
    bus.halt_req = 1'b0;
    bus.step_req = 1'b0;
    bus.bp_hit   = 1'b0;
  endtask

  task automatic doReset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST             = 1'b1;
    bus.run_req     = 1'b0;
    bus.halt_req    = 1'b0;
    bus.step_req    = 1'b0;
    bus.bp_hit      = 1'b0;
    bus.step_count  = '0;
    bus.div_ratio   = '0;
    bus2.run_req    = 1'b0;
    bus2.halt_req   = 1'b0;
    bus2.step_req   = 1'b0;
    bus2.bp_hit     = 1'b0;
    bus2.step_count = '0;
    bus2.div_ratio  = '0;
    @(negedge CLK);

    // Reset state, then free run at ratio 3 for five pulses and halt.
    doReset();
    checkOutput("rst_state", 32'(bus.state), 0);
    checkOutput("rst_ce", 32'(bus.cpu_ce), 0);
    checkOutput("rst_done", 32'(bus.done), 0);
    checkOutput("rst_count", bus.cycle_count, 0);
    bus.div_ratio = 8'd3;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("run_state", 32'(bus.state), 1);
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge CLK);
      checkOutput($sformatf("run_ce_%0d", k), 32'(bus.cpu_ce), (k % 4 == 0) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("halt_state", 32'(bus.state), 0);
    checkOutput("halt_count", bus.cycle_count, 5);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("halted_ce_%0d", k), 32'(bus.cpu_ce), 0);
      @(negedge CLK);
    end

    // Step of 3 at ratio 0, then step_count=0 behaves as 1.
    doReset();
    bus.div_ratio  = 8'd0;
    bus.step_count = 16'd3;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge CLK);
      checkOutput($sformatf("step3_state_%0d", k), 32'(bus.state), 2);
      checkOutput($sformatf("step3_ce_%0d", k), 32'(bus.cpu_ce), 1);
      checkOutput($sformatf("step3_done_%0d", k), 32'(bus.done), 0);
    end
    @(negedge CLK);
    checkOutput("step3_end_state", 32'(bus.state), 0);
    checkOutput("step3_end_done", 32'(bus.done), 1);
    checkOutput("step3_end_ce", 32'(bus.cpu_ce), 0);
    checkOutput("step3_end_count", bus.cycle_count, 3);
    @(negedge CLK);
    checkOutput("step3_done_clear", 32'(bus.done), 0);
    bus.step_count = 16'd0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("step0_state", 32'(bus.state), 2);
    checkOutput("step0_ce", 32'(bus.cpu_ce), 1);
    @(negedge CLK);
    checkOutput("step0_end_state", 32'(bus.state), 0);
    checkOutput("step0_end_done", 32'(bus.done), 1);
    checkOutput("step0_end_ce", 32'(bus.cpu_ce), 0);
    checkOutput("step0_end_count", bus.cycle_count, 4);
    @(negedge CLK);
    checkOutput("step0_done_clear", 32'(bus.done), 0);

    // Breakpoint on the 2nd pulse at ratio 1, resume, ignored bp, break again, halt.
    doReset();
    bus.div_ratio = 8'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_ce_1", 32'(bus.cpu_ce), 0);
    @(negedge CLK);
    checkOutput("bp_ce_2", 32'(bus.cpu_ce), 1);
    @(negedge CLK);
    checkOutput("bp_ce_3", 32'(bus.cpu_ce), 0);
    @(negedge CLK);
    checkOutput("bp_ce_4", 32'(bus.cpu_ce), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_state", 32'(bus.state), 3);
    checkOutput("bp_count", bus.cycle_count, 2);
    checkOutput("bp_ce_held", 32'(bus.cpu_ce), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("resume_state", 32'(bus.state), 1);
    checkOutput("resume_ce_1", 32'(bus.cpu_ce), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_no_ce_state", 32'(bus.state), 1);
    checkOutput("resume_ce_2", 32'(bus.cpu_ce), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bp2_state", 32'(bus.state), 3);
    checkOutput("bp2_count", bus.cycle_count, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("break_halt_state", 32'(bus.state), 0);

    // Priority: halt beats run, halt beats bp, step beats run; halt aborts step with no done.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("halt_run_state", 32'(bus.state), 0);
    checkOutput("halt_run_ce", 32'(bus.cpu_ce), 0);
    bus.div_ratio = 8'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    checkOutput("prio_ce", 32'(bus.cpu_ce), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("halt_bp_state", 32'(bus.state), 0);
    checkOutput("halt_bp_count", bus.cycle_count, 1);
    bus.step_count = 16'd2;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("step_run_state", 32'(bus.state), 2);
    checkOutput("step_run_ce", 32'(bus.cpu_ce), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("step_halt_state", 32'(bus.state), 0);
    checkOutput("step_halt_done", 32'(bus.done), 0);
    @(negedge CLK);
    checkOutput("step_halt_done2", 32'(bus.done), 0);
    checkOutput("step_halt_count", bus.cycle_count, 1);

    // Reset in the middle of a step sequence.
    doReset();
    bus.div_ratio  = 8'd0;
    bus.step_count = 16'd4;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("abort_ce_1", 32'(bus.cpu_ce), 1);
    @(negedge CLK);
    checkOutput("abort_ce_2", 32'(bus.cpu_ce), 1);
    checkOutput("abort_count_pre", bus.cycle_count, 1);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("abort_state", 32'(bus.state), 0);
    checkOutput("abort_count", bus.cycle_count, 0);
    checkOutput("abort_ce", 32'(bus.cpu_ce), 0);
    checkOutput("abort_done", 32'(bus.done), 0);
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checkOutput($sformatf("abort_done_%0d", k), 32'(bus.done), 0);
      checkOutput($sformatf("abort_ce_after_%0d", k), 32'(bus.cpu_ce), 0);
    end

    // Counter wrap on the 4-bit instance: 16 pulses take 15 back to 0.
    doReset();
    bus2.div_ratio  = 8'd0;
    bus2.step_count = 16'd16;
    bus2.step_req   = 1'b1;
    @(negedge CLK);
    bus2.step_req   = 1'b0;
    checkOutput("wrap_count_start", 32'(bus2.cycle_count), 0);
    repeat (15) @(negedge CLK);
    checkOutput("wrap_count_max", 32'(bus2.cycle_count), 15);
    checkOutput("wrap_ce_last", 32'(bus2.cpu_ce), 1);
    @(negedge CLK);
    checkOutput("wrap_count_zero", 32'(bus2.cycle_count), 0);
    checkOutput("wrap_state", 32'(bus2.state), 0);
    checkOutput("wrap_done", 32'(bus2.done), 1);

    // div_ratio changes mid-run are ignored until the next entry.
    doReset();
    bus.div_ratio = 8'd2;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    bus.div_ratio = 8'd0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge CLK);
      checkOutput($sformatf("ratio_hold_ce_%0d", k), 32'(bus.cpu_ce), (k % 3 == 0) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ratio_halt_count", bus.cycle_count, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("ratio_new_ce_1", 32'(bus.cpu_ce), 1);
    @(negedge CLK);
    checkOutput("ratio_new_ce_2", 32'(bus.cpu_ce), 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
